// File: rtl/pc_unit.sv
// Program counter with trap/redirect/RAS/call/sequential next-PC selection and RUN/HALT control.
// One-cycle latency from request to outPC; ready stalls only the call/return/sequential sources.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INCR         = 1,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ready,
  input  logic            trapValid,
  input  logic [XLEN-1:0] trapTarget,
  input  logic            redirectValid,
  input  logic [XLEN-1:0] redirectTarget,
  input  logic            callValid,
  input  logic [XLEN-1:0] callTarget,
  input  logic            retValid,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] outPC,
  output logic [XLEN-1:0] outPCPlusInc,
  output logic            outRasValid,
  output logic            outRasOverflow,
  output logic            outRasUnderflow,
  output logic            outHalted
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic            r_unf;

  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_ras_top;
  logic [XLEN-1:0] w_next_pc;
  logic [PW-1:0]   w_top_idx;
  logic            w_run;
  logic            w_fetch;
  logic            w_ras_empty;
  logic            w_ras_full;
  logic            w_ret_hit;
  logic            w_pop;
  logic            w_swap;
  logic            w_push;
  logic            w_underflow;

  assign w_pc_inc    = r_pc + XLEN'(INCR);
  assign w_top_idx   = r_ptr - PW'(1);
  assign w_ras_top   = r_ras[w_top_idx];
  assign w_run       = (r_state == S_RUN);
  // Lower-priority sources only act when nothing above them claimed the cycle.
  assign w_fetch     = w_run & ~trapValid & ~redirectValid & ~halt & ready;
  assign w_ras_empty = (r_cnt == '0);
  assign w_ras_full  = (r_cnt == CW'(RAS_DEPTH));
  assign w_ret_hit   = w_fetch & retValid & ~w_ras_empty;
  assign w_pop       = w_ret_hit & ~callValid;
  assign w_swap      = w_ret_hit & callValid;
  assign w_push      = w_fetch & callValid & ~w_ret_hit;
  assign w_underflow = w_fetch & retValid & w_ras_empty;

  always_comb begin
    w_next_pc = r_pc;
    if (trapValid)
      w_next_pc = trapTarget;
    else if (w_run && redirectValid)
      w_next_pc = redirectTarget;
    else if (w_ret_hit)
      w_next_pc = w_ras_top;
    else if (w_push)
      w_next_pc = callTarget;
    else if (w_fetch)
      w_next_pc = w_pc_inc;
  end

  // Entry storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (w_push)
      r_ras[r_ptr] <= w_pc_inc;
    else if (w_swap)
      r_ras[w_top_idx] <= w_pc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_pc    <= RESET_VECTOR;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc  <= w_next_pc;
      r_unf <= w_underflow;

      if (trapValid)
        r_cnt <= '0;
      else if (w_push && !w_ras_full)
        r_cnt <= r_cnt + CW'(1);
      else if (w_pop)
        r_cnt <= r_cnt - CW'(1);

      if (w_push)
        r_ptr <= r_ptr + PW'(1);
      else if (w_pop)
        r_ptr <= w_top_idx;

      if (w_push && w_ras_full)
        r_ovf <= 1'b1;

      case (r_state)
        S_RUN:  if (!trapValid && !redirectValid && halt) r_state <= S_HALT;
        S_HALT: if (trapValid || resume) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign outPC           = r_pc;
  assign outPCPlusInc    = w_pc_inc;
  assign outRasValid     = ~w_ras_empty;
  assign outRasOverflow  = r_ovf;
  assign outRasUnderflow = r_unf;
  assign outHalted       = (r_state == S_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit (XLEN=32, INCR=4, RESET_VECTOR=0x100, RAS_DEPTH=4).
module tb_pc_unit;

  localparam int XLEN = 32;
  localparam int INCR = 4;
  localparam logic [31:0] RV = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready, trapValid, redirectValid, callValid, retValid, halt, resume;
  logic [31:0] trapTarget, redirectTarget, callTarget;
  logic [31:0] outPC, outPCPlusInc;
  logic        outRasValid, outRasOverflow, outRasUnderflow, outHalted;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .INCR(INCR), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .trapValid(trapValid), .trapTarget(trapTarget),
    .redirectValid(redirectValid), .redirectTarget(redirectTarget),
    .callValid(callValid), .callTarget(callTarget),
    .retValid(retValid), .halt(halt), .resume(resume),
    .outPC(outPC), .outPCPlusInc(outPCPlusInc),
    .outRasValid(outRasValid), .outRasOverflow(outRasOverflow),
    .outRasUnderflow(outRasUnderflow), .outHalted(outHalted)
  );

  typedef struct {
    logic        trap;
    logic [31:0] tt;
    logic        rd;
    logic [31:0] rt;
    logic        call;
    logic [31:0] ct;
    logic        ret;
    logic        hlt;
    logic        res;
    logic        rdy;
    logic [31:0] epc;
    logic [3:0]  eflags;   // {rasValid, overflow, underflow, halted}
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic trap, input logic [31:0] tt,
                              input logic rd, input logic [31:0] rt,
                              input logic call, input logic [31:0] ct,
                              input logic ret, input logic hlt, input logic res,
                              input logic rdy, input logic [31:0] epc,
                              input logic [3:0] eflags);
    vec_t v;
    v.trap = trap; v.tt = tt; v.rd = rd; v.rt = rt; v.call = call; v.ct = ct;
    v.ret = ret; v.hlt = hlt; v.res = res; v.rdy = rdy; v.epc = epc; v.eflags = eflags;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [31:0] epc, input logic [3:0] ef);
    logic [31:0] einc;
    einc = epc + 32'(INCR);
    chk({tag, "_pc"}, idx, outPC, epc);
    chk({tag, "_pcinc"}, idx, outPCPlusInc, einc);
    chk({tag, "_flags"}, idx, {28'd0, outRasValid, outRasOverflow, outRasUnderflow, outHalted},
        {28'd0, ef});
  endtask

  task automatic drive(input vec_t v);
    trapValid = v.trap; trapTarget = v.tt;
    redirectValid = v.rd; redirectTarget = v.rt;
    callValid = v.call; callTarget = v.ct;
    retValid = v.ret; halt = v.hlt; resume = v.res; ready = v.rdy;
  endtask

  initial begin
    // trap tt rd rt call ct ret hlt res rdy | epc flags{rv,ovf,unf,hlt}
    // sequential fetch and stall
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 32'h104, 4'b0000));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 32'h108, 4'b0000));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 32'h10C, 4'b0000));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 32'h10C, 4'b0000));
    // priority, ready-independence of redirect/trap
    tbl.push_back(mk(0,0,1,32'h200,0,0,0,0,0,0, 32'h200, 4'b0000));
    tbl.push_back(mk(0,0,1,32'h400,1,32'h800,0,0,0,0, 32'h400, 4'b0000));
    tbl.push_back(mk(0,0,0,0,1,32'h800,0,0,0,1, 32'h800, 4'b1000));
    tbl.push_back(mk(1,32'h10,1,32'h400,1,32'h800,0,0,0,0, 32'h010, 4'b0000));
    // call / return pairing
    tbl.push_back(mk(0,0,1,32'h100,0,0,0,0,0,0, 32'h100, 4'b0000));
    tbl.push_back(mk(0,0,0,0,1,32'h500,0,0,0,1, 32'h500, 4'b1000));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 32'h504, 4'b1000));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 32'h508, 4'b1000));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0,1, 32'h104, 4'b0000));
    // five calls into a 4-deep stack, then drain
    tbl.push_back(mk(0,0,0,0,1,32'h1000,0,0,0,1, 32'h1000, 4'b1000));
    tbl.push_back(mk(0,0,0,0,1,32'h2000,0,0,0,1, 32'h2000, 4'b1000));
    tbl.push_back(mk(0,0,0,0,1,32'h3000,0,0,0,1, 32'h3000, 4'b1000));
    tbl.push_back(mk(0,0,0,0,1,32'h4000,0,0,0,1, 32'h4000, 4'b1000));
    tbl.push_back(mk(0,0,0,0,1,32'h5000,0,0,0,1, 32'h5000, 4'b1100));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0,1, 32'h4004, 4'b1100));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0,1, 32'h3004, 4'b1100));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0,1, 32'h2004, 4'b1100));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0,1, 32'h1004, 4'b0100));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0,1, 32'h1008, 4'b0110));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 32'h100C, 4'b0100));
    // back-to-back underflows
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0,1, 32'h1010, 4'b0110));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0,1, 32'h1014, 4'b0110));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 32'h1018, 4'b0100));
    // co-routine swap, with and without stack content
    tbl.push_back(mk(0,0,0,0,1,32'h6000,0,0,0,1, 32'h6000, 4'b1100));
    tbl.push_back(mk(0,0,0,0,1,32'h7000,1,0,0,1, 32'h101C, 4'b1100));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0,1, 32'h6004, 4'b0100));
    tbl.push_back(mk(0,0,0,0,1,32'h8000,1,0,0,1, 32'h8000, 4'b1110));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0,1, 32'h6008, 4'b0100));
    // HALT
    tbl.push_back(mk(0,0,1,32'h300,0,0,0,0,0,0, 32'h300, 4'b0100));
    tbl.push_back(mk(0,0,0,0,1,32'h900,0,1,0,1, 32'h300, 4'b0101));
    tbl.push_back(mk(0,0,1,32'h999,1,32'h900,1,0,0,1, 32'h300, 4'b0101));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0, 32'h300, 4'b0100));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 32'h304, 4'b0100));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,1, 32'h304, 4'b0101));
    tbl.push_back(mk(1,32'h40,0,0,0,0,0,0,1,0, 32'h040, 4'b0100));
    // wrap
    tbl.push_back(mk(1,32'hFFFFFFFC,0,0,0,0,0,0,0,0, 32'hFFFFFFFC, 4'b0100));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1, 32'h0, 4'b0100));
    tbl.push_back(mk(0,0,0,0,1,32'h20,0,0,0,1, 32'h20, 4'b1100));
    // resume while running does nothing
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1, 32'h24, 4'b1100));

    rst_n = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1 check_all("reset", 0, RV, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk);
      #1 check_all("vec", i, tbl[i].epc, tbl[i].eflags);
    end

    // asynchronous reset between edges
    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,0,0,1,0,0));
    #2 rst_n = 1'b0;
    #1 check_all("areset", 0, RV, 4'b0000);
    @(posedge clk);
    #1 check_all("areset_hold", 0, RV, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all("areset_rel", 0, RV, 4'b0000);
    @(posedge clk);
    #1 check_all("areset_first", 0, RV + 32'(INCR), 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
